// File: rtl/sat_accum.sv
`default_nettype none
// ============================================================================
//  Module      : sat_accum
//  Description : Multi-channel signed saturating frame accumulator.
//                Each input beat adds (or subtracts) a signed sample to the
//                accumulator of its channel, saturating at the signed
//                DATA_WIDTH limits. The beat flagged "last" closes the
//                channel's frame. The frame result, the sticky saturation
//                flag and the beat count are then loaded into a one-entry
//                output register, and that channel's state is cleared.
//  Ports       : clk_i, rst_i  - clock, synchronous active-high reset
//                clr_i         - synchronous clear of all channel state
//                s_*           - input beat stream (valid/ready handshake)
//                m_*           - frame result stream (valid/ready handshake)
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_accum #(
    parameter  int DATA_WIDTH = 16,
    parameter  int NUM_CH     = 4,
    parameter  int CNT_WIDTH  = 8,
    localparam int CH_WIDTH   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clr_i,
    input  logic                         s_valid_i,
    output logic                         s_ready_o,
    input  logic signed [DATA_WIDTH-1:0] s_data_i,
    input  logic        [CH_WIDTH-1:0]   s_ch_i,
    input  logic                         s_sub_i,
    input  logic                         s_last_i,
    output logic                         m_valid_o,
    input  logic                         m_ready_i,
    output logic signed [DATA_WIDTH-1:0] m_data_o,
    output logic        [CH_WIDTH-1:0]   m_ch_o,
    output logic                         m_sat_o,
    output logic        [CNT_WIDTH-1:0]  m_cnt_o
);

    localparam logic [CH_WIDTH:0]   c_num_ch  = (CH_WIDTH+1)'(NUM_CH);
    localparam logic [DATA_WIDTH-1:0] c_max   = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] c_min   = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Per-channel state
    // ------------------------------------------------------------------
    logic signed [DATA_WIDTH-1:0] r_acc [NUM_CH];
    logic                         r_sat [NUM_CH];
    logic        [CNT_WIDTH-1:0]  r_cnt [NUM_CH];

    // Output register and its FSM
    state_t                       r_state;
    state_t                       w_state_next;
    logic signed [DATA_WIDTH-1:0] r_m_data;
    logic        [CH_WIDTH-1:0]   r_m_ch;
    logic                         r_m_sat;
    logic        [CNT_WIDTH-1:0]  r_m_cnt;

    // Beat datapath
    logic                         w_accept;
    logic                         w_ch_ok;
    logic                         w_beat;
    logic                         w_last_beat;
    logic        [CH_WIDTH-1:0]   w_idx;
    logic signed [DATA_WIDTH-1:0] w_acc_cur;
    logic                         w_sat_cur;
    logic        [CNT_WIDTH-1:0]  w_cnt_cur;
    logic signed [DATA_WIDTH:0]   w_op_a;
    logic signed [DATA_WIDTH:0]   w_op_b;
    logic signed [DATA_WIDTH:0]   w_sum;
    logic signed [DATA_WIDTH-1:0] w_result;
    logic                         w_sat_hit;
    logic        [CNT_WIDTH-1:0]  w_cnt_next;

    assign m_valid_o = (r_state == S_FULL);
    assign s_ready_o = !clr_i && (!m_valid_o || m_ready_i);

    assign w_accept    = s_valid_i && s_ready_o;
    // Beats addressed to a channel that does not exist are consumed silently.
    assign w_ch_ok     = ({1'b0, s_ch_i} < c_num_ch);
    assign w_beat      = w_accept && w_ch_ok;
    assign w_last_beat = w_beat && s_last_i;
    // Keep the array read index in range even for discarded beats.
    assign w_idx       = w_ch_ok ? s_ch_i : '0;

    assign w_acc_cur = r_acc[w_idx];
    assign w_sat_cur = r_sat[w_idx];
    assign w_cnt_cur = r_cnt[w_idx];

    // One guard bit is enough to hold any sum or difference of two
    // DATA_WIDTH signed values, including 0 - min.
    assign w_op_a = {w_acc_cur[DATA_WIDTH-1], w_acc_cur};
    assign w_op_b = {s_data_i[DATA_WIDTH-1], s_data_i};
    assign w_sum  = s_sub_i ? (w_op_a - w_op_b) : (w_op_a + w_op_b);

    always_comb begin
        w_result  = w_sum[DATA_WIDTH-1:0];
        w_sat_hit = 1'b0;
        if (w_sum[DATA_WIDTH] != w_sum[DATA_WIDTH-1]) begin
            w_sat_hit = 1'b1;
            w_result  = w_sum[DATA_WIDTH] ? c_min : c_max;
        end
    end

    // The beat counter sticks at all-ones instead of wrapping.
    assign w_cnt_next = (&w_cnt_cur) ? w_cnt_cur : (w_cnt_cur + 1'b1);

    // ------------------------------------------------------------------
    // Channel state update
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (rst_i || clr_i) begin
                r_acc[i] <= '0;
                r_sat[i] <= 1'b0;
                r_cnt[i] <= '0;
            end else if (w_beat && (w_idx == CH_WIDTH'(i))) begin
                if (s_last_i) begin
                    r_acc[i] <= '0;
                    r_sat[i] <= 1'b0;
                    r_cnt[i] <= '0;
                end else begin
                    r_acc[i] <= w_result;
                    r_sat[i] <= w_sat_cur | w_sat_hit;
                    r_cnt[i] <= w_cnt_next;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_EMPTY: begin
                if (w_last_beat) begin
                    w_state_next = S_FULL;
                end
            end
            S_FULL: begin
                // A last beat can only be accepted here while the current
                // result is being drained, so the slot refills with no bubble.
                if (m_ready_i && !w_last_beat) begin
                    w_state_next = S_EMPTY;
                end
            end
            default: begin
                w_state_next = S_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_m_data <= '0;
            r_m_ch   <= '0;
            r_m_sat  <= 1'b0;
            r_m_cnt  <= '0;
        end else if (w_last_beat) begin
            r_m_data <= w_result;
            r_m_ch   <= s_ch_i;
            r_m_sat  <= w_sat_cur | w_sat_hit;
            r_m_cnt  <= w_cnt_next;
        end
    end

    assign m_data_o = r_m_data;
    assign m_ch_o   = r_m_ch;
    assign m_sat_o  = r_m_sat;
    assign m_cnt_o  = r_m_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sat_accum.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sat_accum
//  Description : Self-checking bench for sat_accum (16-bit, 4 channels,
//                8-bit counter). Expected frame results are queued when the
//                closing beat is accepted and compared as they are drained.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sat_accum;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic               clr_i;
    logic               s_valid_i;
    logic               s_ready_o;
    logic signed [15:0] s_data_i;
    logic        [1:0]  s_ch_i;
    logic               s_sub_i;
    logic               s_last_i;
    logic               m_valid_o;
    logic               m_ready_i;
    logic signed [15:0] m_data_o;
    logic        [1:0]  m_ch_o;
    logic               m_sat_o;
    logic        [7:0]  m_cnt_o;

    typedef struct {
        logic signed [15:0] data;
        logic        [1:0]  ch;
        logic               sat;
        logic        [7:0]  cnt;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    sat_accum #(
        .DATA_WIDTH (16),
        .NUM_CH     (4),
        .CNT_WIDTH  (8)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (clr_i),
        .s_valid_i (s_valid_i),
        .s_ready_o (s_ready_o),
        .s_data_i  (s_data_i),
        .s_ch_i    (s_ch_i),
        .s_sub_i   (s_sub_i),
        .s_last_i  (s_last_i),
        .m_valid_o (m_valid_o),
        .m_ready_i (m_ready_i),
        .m_data_o  (m_data_o),
        .m_ch_o    (m_ch_o),
        .m_sat_o   (m_sat_o),
        .m_cnt_o   (m_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drain monitor: a handshake seen at the falling edge completes on the
    // next rising edge, so the result is checked against the queue head now.
    always @(negedge clk_i) begin
        if (!rst_i && m_valid_o && m_ready_i) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_result: got data=%0d ch=%0d sat=%0b cnt=%0d, required none",
                         m_data_o, m_ch_o, m_sat_o, m_cnt_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (m_data_o !== e.data || m_ch_o !== e.ch ||
                    m_sat_o !== e.sat || m_cnt_o !== e.cnt) begin
                    bad++;
                    $display("FAIL result: got data=%0d ch=%0d sat=%0b cnt=%0d, required data=%0d ch=%0d sat=%0b cnt=%0d",
                             m_data_o, m_ch_o, m_sat_o, m_cnt_o, e.data, e.ch, e.sat, e.cnt);
                end
            end
        end
    end

    // Drives one beat starting just after a rising edge; returns just after
    // a rising edge. A last beat queues its expected result on acceptance
    // and the result must be valid exactly one cycle later.
    task automatic send_beat(input logic [1:0] ch, input logic signed [15:0] d,
                             input logic sub, input logic last,
                             input logic signed [15:0] e_data, input logic e_sat,
                             input logic [7:0] e_cnt);
        int  waited;
        bit  ok;
        exp_t e;
        s_valid_i = 1'b1;
        s_ch_i    = ch;
        s_data_i  = d;
        s_sub_i   = sub;
        s_last_i  = last;
        waited    = 0;
        @(negedge clk_i);
        while (!s_ready_o && waited < 20) begin
            @(negedge clk_i);
            waited++;
        end
        ok = s_ready_o;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: ch=%0d s_ready_o=%0b, required 1", ch, s_ready_o);
        end else if (last) begin
            e.data = e_data;
            e.ch   = ch;
            e.sat  = e_sat;
            e.cnt  = e_cnt;
            sb.push_back(e);
        end
        @(posedge clk_i);
        #1;
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
        if (ok && last) begin
            @(negedge clk_i);
            total++;
            if (m_valid_o !== 1'b1) begin
                bad++;
                $display("FAIL latency: m_valid_o=%0b one cycle after last beat, required 1", m_valid_o);
            end
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic test_reset();
        // Partial ch0 frame plus a pending result, both must vanish.
        m_ready_i = 1'b0;
        send_beat(2'd0, 16'sd99, 1'b0, 1'b0, 16'sd0, 1'b0, 8'd0);
        send_beat(2'd1, 16'sd7,  1'b0, 1'b1, 16'sd7, 1'b0, 8'd1);
        sb.delete();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        total++;
        if (m_valid_o !== 1'b0 || m_data_o !== 16'sd0 || m_ch_o !== 2'd0 ||
            m_sat_o !== 1'b0 || m_cnt_o !== 8'd0 || s_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL reset_state: valid=%0b data=%0d ch=%0d sat=%0b cnt=%0d ready=%0b, required 0 0 0 0 0 1",
                     m_valid_o, m_data_o, m_ch_o, m_sat_o, m_cnt_o, s_ready_o);
        end
        @(posedge clk_i);
        #1;
        m_ready_i = 1'b1;
        send_beat(2'd0, 16'sd5, 1'b0, 1'b1, 16'sd5, 1'b0, 8'd1);
    endtask

    task automatic test_basic();
        send_beat(2'd0, 16'sd100, 1'b0, 1'b0, 16'sd0,   1'b0, 8'd0);
        send_beat(2'd0, 16'sd200, 1'b0, 1'b0, 16'sd0,   1'b0, 8'd0);
        send_beat(2'd0, 16'sd300, 1'b0, 1'b1, 16'sd600, 1'b0, 8'd3);
    endtask

    task automatic test_saturation();
        send_beat(2'd1, 16'sd32767, 1'b0, 1'b0, 16'sd0,     1'b0, 8'd0);
        send_beat(2'd1, 16'sd1,     1'b0, 1'b0, 16'sd0,     1'b0, 8'd0);
        send_beat(2'd1, -16'sd10,   1'b0, 1'b1, 16'sd32757, 1'b1, 8'd3);
        send_beat(2'd2, -16'sd32768, 1'b1, 1'b1, 16'sd32767, 1'b1, 8'd1);
        send_beat(2'd3, -16'sd32768, 1'b0, 1'b0, 16'sd0,      1'b0, 8'd0);
        send_beat(2'd3, 16'sd1,      1'b1, 1'b1, -16'sd32768, 1'b1, 8'd2);
    endtask

    task automatic test_interleave();
        send_beat(2'd0, 16'sd10, 1'b0, 1'b0, 16'sd0,  1'b0, 8'd0);
        send_beat(2'd1, 16'sd20, 1'b0, 1'b0, 16'sd0,  1'b0, 8'd0);
        send_beat(2'd0, 16'sd30, 1'b0, 1'b1, 16'sd40, 1'b0, 8'd2);
        send_beat(2'd1, 16'sd40, 1'b0, 1'b1, 16'sd60, 1'b0, 8'd2);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        m_ready_i = 1'b0;
        send_beat(2'd2, 16'sd11, 1'b0, 1'b1, 16'sd11, 1'b0, 8'd1);
        // Present the next closing beat while the result is stalled.
        s_valid_i = 1'b1;
        s_ch_i    = 2'd3;
        s_data_i  = 16'sd22;
        s_sub_i   = 1'b0;
        s_last_i  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            total++;
            if (s_ready_o !== 1'b0 || m_valid_o !== 1'b1 || m_data_o !== 16'sd11 ||
                m_ch_o !== 2'd2 || m_sat_o !== 1'b0 || m_cnt_o !== 8'd1) begin
                bad++;
                $display("FAIL stall_hold: ready=%0b valid=%0b data=%0d ch=%0d sat=%0b cnt=%0d, required 0 1 11 2 0 1",
                         s_ready_o, m_valid_o, m_data_o, m_ch_o, m_sat_o, m_cnt_o);
            end
        end
        @(posedge clk_i);
        #1;
        m_ready_i = 1'b1;
        @(negedge clk_i);
        total++;
        if (s_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL drain_ready: s_ready_o=%0b, required 1", s_ready_o);
        end else begin
            e.data = 16'sd22;
            e.ch   = 2'd3;
            e.sat  = 1'b0;
            e.cnt  = 8'd1;
            sb.push_back(e);
        end
        @(posedge clk_i);
        #1;
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
        @(negedge clk_i);
        total++;
        if (m_valid_o !== 1'b1 || m_data_o !== 16'sd22) begin
            bad++;
            $display("FAIL no_bubble: valid=%0b data=%0d, required 1 22", m_valid_o, m_data_o);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_clear();
        send_beat(2'd0, 16'sd500, 1'b0, 1'b0, 16'sd0, 1'b0, 8'd0);
        clr_i     = 1'b1;
        s_valid_i = 1'b1;
        s_ch_i    = 2'd0;
        s_data_i  = 16'sd1000;
        s_sub_i   = 1'b0;
        s_last_i  = 1'b1;
        @(negedge clk_i);
        total++;
        if (s_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL clear_ready: s_ready_o=%0b, required 0", s_ready_o);
        end
        @(posedge clk_i);
        #1;
        clr_i     = 1'b0;
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
        send_beat(2'd0, 16'sd7, 1'b0, 1'b1, 16'sd7, 1'b0, 8'd1);
    endtask

    task automatic test_count_saturate();
        // 257 beats in one frame: the count must stick at 255.
        for (int i = 0; i < 256; i++) begin
            send_beat(2'd2, 16'sd0, 1'b0, 1'b0, 16'sd0, 1'b0, 8'd0);
        end
        send_beat(2'd2, 16'sd3, 1'b0, 1'b1, 16'sd3, 1'b0, 8'd255);
    endtask

    initial begin
        rst_i     = 1'b1;
        clr_i     = 1'b0;
        s_valid_i = 1'b0;
        s_data_i  = '0;
        s_ch_i    = '0;
        s_sub_i   = 1'b0;
        s_last_i  = 1'b0;
        m_ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        test_reset();
        test_basic();
        test_saturation();
        test_interleave();
        test_back_to_back();
        test_clear();
        test_count_saturate();

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain_complete: %0d results outstanding, required 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
